// File: rtl/pwl_integrate_dump_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pwl_intdump_pkg
//  Description : Shared types and helpers for the PWL integrate-and-dump
//                controller: FSM state encoding, counter-width function and
//                analytic PWL evaluation / clipping helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwl_intdump_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DUMP   = 2'd1,
        INTEG  = 2'd2,
        DECIDE = 2'd3
    } intdump_state_t;

    // $realtime is reported in ns by every file of this block; PWL slopes
    // and t0 values are in seconds.
    localparam real TIME_UNIT_S = 1.0e-9;

    // Width of a down-counter that must hold max(n_dump, n_int).
    function automatic int cnt_width(input int n_dump, input int n_int);
        int m;
        m = (n_dump > n_int) ? n_dump : n_int;
        return $clog2(m + 1);
    endfunction

    // PWL segment value a + b*(t - t0), t in seconds.
    function automatic real pwl_eval(input real a, input real b,
                                     input real t0, input real t);
        return a + b * (t - t0);
    endfunction

    function automatic real pwl_abs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real pwl_clip(input real v, input real lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic real pwl_max(input real x, input real y);
        return (x > y) ? x : y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwl_integrate_dump_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pwl_integrate_dump_ctrl_if
//  Description : Frame request / decision bus of the integrate-and-dump
//                controller.
//                  start     : frame request (level, client -> controller)
//                  busy      : frame in progress
//                  dec       : registered decision
//                  dec_valid : one-cycle decision strobe
//                  sample    : registered clipped sample (real)
//                  sat       : last sample was clipped
//                  peak      : running peak (only with PWL_INTDUMP_PEAK_EN)
//  Macro       : PWL_INTDUMP_PEAK_EN adds the peak signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwl_integrate_dump_ctrl_if;
    logic start;
    logic busy;
    logic dec;
    logic dec_valid;
    real  sample;
    logic sat;
`ifdef PWL_INTDUMP_PEAK_EN
    real  peak;

    modport master (input start, output busy, output dec, output dec_valid,
                    output sample, output sat, output peak);
    modport slave  (output start, input busy, input dec, input dec_valid,
                    input sample, input sat, input peak);
`else
    modport master (input start, output busy, output dec, output dec_valid,
                    output sample, output sat);
    modport slave  (output start, input busy, input dec, input dec_valid,
                    input sample, input sat);
`endif
endinterface
`default_nettype wire

// File: rtl/pwl_integrate_dump_ctrl_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pwl_clk_sampler
//  Description : Evaluates a PWL input analytically at the rising clock edge
//                and registers the clipped value and a saturation flag.
//                In PEAK_MODE the register keeps the running maximum of the
//                clipped samples instead of the latest one.
//  Ports       : clk, reset (sync, active-high)
//                clr_i        load -vclip (peak restart), sat cleared
//                en_i         take a sample at this edge
//                a_i,b_i,t0_i PWL segment being sampled
//                val_o        registered clipped value / running peak
//                sat_o        last sample exceeded +/-vclip
//  Revision    : 1.0 - initial release
// ============================================================================
module pwl_clk_sampler
    import pwl_intdump_pkg::*;
#(
    parameter real vclip     = 1.0,
    parameter bit  PEAK_MODE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    input  real  a_i,
    input  real  b_i,
    input  real  t0_i,
    output real  val_o,
    output logic sat_o
);

    real  val_q;
    logic sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= 0.0;
            sat_q <= 1'b0;
        end else if (clr_i) begin
            val_q <= -vclip;
            sat_q <= 1'b0;
        end else if (en_i) begin
            // $realtime inside the edge-triggered block is the edge time
            // itself, so there is no setup window around the sample point.
            if (PEAK_MODE)
                val_q <= pwl_max(val_q, pwl_clip(pwl_eval(a_i, b_i, t0_i,
                                 $realtime * TIME_UNIT_S), vclip));
            else
                val_q <= pwl_clip(pwl_eval(a_i, b_i, t0_i,
                                  $realtime * TIME_UNIT_S), vclip);
            sat_q <= (pwl_abs(pwl_eval(a_i, b_i, t0_i,
                      $realtime * TIME_UNIT_S)) > vclip);
        end
    end

    assign val_o = val_q;
    assign sat_o = sat_q;

endmodule
`default_nettype wire

// File: rtl/pwl_integrate_dump_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pwl_integrate_dump_ctrl
//  Description : Integrate-and-dump controller around a resettable PWL
//                filter. Holds the filter at the dump level, releases it for
//                N_INT cycles, then samples the filter output at the clock
//                edge and produces a registered decision and clipped sample.
//  Ports       : clk, reset (sync, active-high)
//                in_a/in_b/in_t0         filter output PWL (a + b*(t-t0))
//                vrst                    dump level
//                dump                    filter reset (high in IDLE/DUMP)
//                out_rst_a/_b/_t0        constant PWL at vrst for filter in_rst
//                bus (master)            start/busy/dec/dec_valid/sample/sat
//  Macro       : PWL_INTDUMP_PEAK_EN adds bus.peak, the running peak of the
//                clipped filter output over the integration window.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwl_integrate_dump_ctrl
    import pwl_intdump_pkg::*;
#(
    parameter int  N_DUMP = 2,
    parameter int  N_INT  = 8,
    parameter real vth    = 0.0,
    parameter real vclip  = 1.0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  real                               in_a,
    input  real                               in_b,
    input  real                               in_t0,
    input  real                               vrst,
    output logic                              dump,
    output real                               out_rst_a,
    output real                               out_rst_b,
    output real                               out_rst_t0,
    pwl_integrate_dump_ctrl_if.master         bus
);

    localparam int CNT_W = cnt_width(N_DUMP, N_INT);

    intdump_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_q;
    logic             sample_en;
    real              sample_w;
    logic             sat_w;

    // ------------------------------------------------------------------
    // Dump-level PWL: flat at vrst, re-anchored whenever vrst moves.
    // ------------------------------------------------------------------
    assign out_rst_a = vrst;
    assign out_rst_b = 0.0;

    always @(vrst) out_rst_t0 = $realtime * TIME_UNIT_S;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DUMP;
                    cnt_d   = CNT_W'(N_DUMP - 1);
                end
            end
            DUMP: begin
                if (cnt_q == '0) begin
                    state_d = INTEG;
                    cnt_d   = CNT_W'(N_INT - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INTEG: begin
                if (cnt_q == '0)
                    state_d = DECIDE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            DECIDE: begin
                // Back-to-back frames restart the dump with no idle gap.
                if (bus.start) begin
                    state_d = DUMP;
                    cnt_d   = CNT_W'(N_DUMP - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Last INTEG edge is the sample point (the DECIDE-entry edge).
    assign sample_en = (state_q == INTEG) && (cnt_q == '0);

    // ------------------------------------------------------------------
    // Sample / saturation path
    // ------------------------------------------------------------------
    pwl_clk_sampler #(
        .vclip     (vclip),
        .PEAK_MODE (1'b0)
    ) u_sampler (
        .clk   (clk),
        .reset (reset),
        .clr_i (1'b0),
        .en_i  (sample_en),
        .a_i   (in_a),
        .b_i   (in_b),
        .t0_i  (in_t0),
        .val_o (sample_w),
        .sat_o (sat_w)
    );

    // Decision is taken on the clipped value at the same edge; a tie with
    // the threshold resolves to 0.
    always_ff @(posedge clk) begin
        if (reset)
            dec_q <= 1'b0;
        else if (sample_en)
            dec_q <= (pwl_clip(pwl_eval(in_a, in_b, in_t0,
                      $realtime * TIME_UNIT_S), vclip) > vth);
    end

`ifdef PWL_INTDUMP_PEAK_EN
    // ------------------------------------------------------------------
    // Peak path: restarted at -vclip on INTEG entry, then max-tracked on
    // every INTEG edge including the DECIDE-entry edge.
    // ------------------------------------------------------------------
    real  peak_w;
    logic peak_sat_unused;

    pwl_clk_sampler #(
        .vclip     (vclip),
        .PEAK_MODE (1'b1)
    ) u_peak (
        .clk   (clk),
        .reset (reset),
        .clr_i ((state_q == DUMP) && (cnt_q == '0)),
        .en_i  (state_q == INTEG),
        .a_i   (in_a),
        .b_i   (in_b),
        .t0_i  (in_t0),
        .val_o (peak_w),
        .sat_o (peak_sat_unused)
    );

    assign bus.peak = peak_w;
`endif

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign dump          = (state_q == IDLE) || (state_q == DUMP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.dec_valid = (state_q == DECIDE);
    assign bus.dec       = dec_q;
    assign bus.sample    = sample_w;
    assign bus.sat       = sat_w;

endmodule
`default_nettype wire

// File: tb/tb_pwl_integrate_dump_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pwl_integrate_dump_ctrl
//  Description : Directed self-checking bench for pwl_integrate_dump_ctrl
//                (N_DUMP=2, N_INT=8, vth=0.0, vclip=1.0, 1 ns clock).
//  Macro       : PWL_INTDUMP_PEAK_EN also checks the peak output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwl_integrate_dump_ctrl;

    localparam real ETOL = 1.0e-6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    real  in_a  = 0.0;
    real  in_b  = 0.0;
    real  in_t0 = 0.0;
    real  vrst  = 0.1;
    logic dump;
    real  out_rst_a;
    real  out_rst_b;
    real  out_rst_t0;

    int checks = 0;
    int errors = 0;

    pwl_integrate_dump_ctrl_if bus();

    pwl_integrate_dump_ctrl #(
        .N_DUMP (2),
        .N_INT  (8),
        .vth    (0.0),
        .vclip  (1.0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_t0      (in_t0),
        .vrst       (vrst),
        .dump       (dump),
        .out_rst_a  (out_rst_a),
        .out_rst_b  (out_rst_b),
        .out_rst_t0 (out_rst_t0),
        .bus        (bus)
    );

    always #0.5 clk = ~clk;

    // Advance one rising edge and settle 100 ps after it.
    task automatic tick();
        @(posedge clk);
        #0.1;
    endtask

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (3) tick();
        checks++; if (dump !== 1'b1)          begin errors++; $display("FAIL rst_dump: got %b exp 1", dump); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.dec !== 1'b0)       begin errors++; $display("FAIL rst_dec: got %b exp 0", bus.dec); end
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid: got %b exp 0", bus.dec_valid); end
        checks++; if (bus.sat !== 1'b0)       begin errors++; $display("FAIL rst_sat: got %b exp 0", bus.sat); end
        checks++; if (bus.sample != 0.0)      begin errors++; $display("FAIL rst_sample: got %f exp 0.0", bus.sample); end
        vrst = 0.25;
        #0.2;
        checks++; if (out_rst_a != 0.25 || out_rst_b != 0.0)
            begin errors++; $display("FAIL rst_out_rst: got a=%f b=%f exp a=0.25 b=0.0", out_rst_a, out_rst_b); end
        reset = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_after: got busy=%b exp 0", bus.busy); end
    endtask

    // One-cycle start, constant 0.3: edge-by-edge dump/dec_valid profile.
    task automatic test_single_frame();
        in_a = 0.3; in_b = 0.0; in_t0 = 0.0;
        bus.start = 1'b1;
        tick();                                   // edge 0
        bus.start = 1'b0;
        checks++; if (dump !== 1'b1 || bus.busy !== 1'b1)
            begin errors++; $display("FAIL sf_edge0: got dump=%b busy=%b exp 1 1", dump, bus.busy); end
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++; if (dump !== ((k >= 2 && k <= 10) ? 1'b0 : 1'b1))
                begin errors++; $display("FAIL sf_dump edge %0d: got %b", k, dump); end
            checks++; if (bus.dec_valid !== ((k == 10) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL sf_dec_valid edge %0d: got %b", k, bus.dec_valid); end
            if (k == 10) begin
                checks++; if (bus.dec !== 1'b1) begin errors++; $display("FAIL sf_dec: got %b exp 1", bus.dec); end
                checks++; if (rabs(bus.sample - 0.3) > ETOL) begin errors++; $display("FAIL sf_sample: got %f exp 0.3", bus.sample); end
                checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL sf_sat: got %b exp 0", bus.sat); end
`ifdef PWL_INTDUMP_PEAK_EN
                checks++; if (rabs(bus.peak - 0.3) > ETOL) begin errors++; $display("FAIL sf_peak: got %f exp 0.3", bus.peak); end
`endif
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sf_idle: got busy=%b exp 0", bus.busy); end
        checks++; if (bus.dec !== 1'b1 || rabs(bus.sample - 0.3) > ETOL)
            begin errors++; $display("FAIL sf_hold: got dec=%b sample=%f exp 1 0.3", bus.dec, bus.sample); end
    endtask

    // start held high: strobe every 11 cycles, negative input decides 0.
    task automatic test_back_to_back();
        int drain;
        in_a = -0.2; in_b = 0.0; in_t0 = 0.0;
        bus.start = 1'b1;
        tick();                                   // edge 0
        for (int k = 1; k <= 33; k++) begin
            tick();
            checks++; if (bus.dec_valid !== (((k % 11) == 10) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL b2b_dec_valid edge %0d: got %b", k, bus.dec_valid); end
            if ((k % 11) == 10) begin
                checks++; if (bus.dec !== 1'b0) begin errors++; $display("FAIL b2b_dec edge %0d: got %b exp 0", k, bus.dec); end
                checks++; if (rabs(bus.sample + 0.2) > ETOL) begin errors++; $display("FAIL b2b_sample edge %0d: got %f exp -0.2", k, bus.sample); end
            end
        end
        bus.start = 1'b0;
        drain = 0;
        while (bus.busy === 1'b1 && drain < 20) begin
            tick();
            drain++;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: busy still %b after %0d cycles", bus.busy, drain); end
    endtask

    // Ramp 1e8 V/s anchored at INTEG entry (edge 2): 8 ns later -> 0.8 V.
    task automatic test_ramp();
        real t_e0;
        in_a = 0.0; in_b = 1.0e8;
        bus.start = 1'b1;
        tick();                                   // edge 0
        t_e0 = $realtime - 0.1;
        bus.start = 1'b0;
        in_t0 = (t_e0 + 2.0) * 1.0e-9;
        repeat (10) tick();                       // edges 1..10
        checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL ramp_dec_valid: got %b exp 1", bus.dec_valid); end
        checks++; if (rabs(bus.sample - 0.8) > ETOL) begin errors++; $display("FAIL ramp_sample: got %f exp 0.8", bus.sample); end
        checks++; if (bus.dec !== 1'b1) begin errors++; $display("FAIL ramp_dec: got %b exp 1", bus.dec); end
`ifdef PWL_INTDUMP_PEAK_EN
        checks++; if (rabs(bus.peak - 0.8) > ETOL) begin errors++; $display("FAIL ramp_peak: got %f exp 0.8", bus.peak); end
`endif
        tick();
    endtask

    // 1.5 V clips to 1.0 with sat; the following 0.5 V frame clears sat.
    task automatic test_saturation();
        in_a = 1.5; in_b = 0.0; in_t0 = 0.0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL sat_dec_valid: got %b exp 1", bus.dec_valid); end
        checks++; if (rabs(bus.sample - 1.0) > ETOL) begin errors++; $display("FAIL sat_sample: got %f exp 1.0", bus.sample); end
        checks++; if (bus.sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b exp 1", bus.sat); end
        tick();
        checks++; if (bus.sat !== 1'b1) begin errors++; $display("FAIL sat_hold: got %b exp 1", bus.sat); end
        in_a = 0.5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL sat2_dec_valid: got %b exp 1", bus.dec_valid); end
        checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL sat2_flag: got %b exp 0", bus.sat); end
        checks++; if (rabs(bus.sample - 0.5) > ETOL) begin errors++; $display("FAIL sat2_sample: got %f exp 0.5", bus.sample); end
        tick();
    endtask

    // Reset during INTEG aborts the frame and clears the held results.
    task automatic test_reset_midframe();
        int pulses;
        in_a = 0.5; in_b = 0.0; in_t0 = 0.0;
        bus.start = 1'b1;
        tick();                                   // edge 0
        bus.start = 1'b0;
        repeat (5) tick();                        // edges 1..5 (INTEG)
        checks++; if (dump !== 1'b0) begin errors++; $display("FAIL mr_in_integ: got dump=%b exp 0", dump); end
        reset = 1'b1;
        tick();                                   // edge 6
        checks++; if (bus.busy !== 1'b0 || dump !== 1'b1)
            begin errors++; $display("FAIL mr_idle: got busy=%b dump=%b exp 0 1", bus.busy, dump); end
        checks++; if (bus.sample != 0.0 || bus.dec !== 1'b0 || bus.sat !== 1'b0)
            begin errors++; $display("FAIL mr_clear: got sample=%f dec=%b sat=%b exp 0.0 0 0", bus.sample, bus.dec, bus.sat); end
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.dec_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mr_no_dec_valid: got %0d pulses exp 0", pulses); end
        bus.start = 1'b1;
        tick();                                   // new edge 0
        bus.start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (bus.dec_valid !== ((k == 10) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL mr_restart edge %0d: got dec_valid=%b", k, bus.dec_valid); end
        end
        checks++; if (bus.dec !== 1'b1 || rabs(bus.sample - 0.5) > ETOL)
            begin errors++; $display("FAIL mr_restart_result: got dec=%b sample=%f exp 1 0.5", bus.dec, bus.sample); end
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ramp();
        test_saturation();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
